text_stream_source: RTL
=======================

// Module: text_stream_source
// PURPOSE
//  Parametrised message source for the text transmit chain. On start, it reads
//  msg_len words from an external synchronous ROM (1-cycle read latency),
//  starting at address 0. It streams the words out on a valid/ready interface
//  with start/end-of-message markers, optionally looping. It sits between the
//  text ROM and the framer/modulator and replaces the free-running byte source.
// PARAMETERS
//  DATA_W  8     width of a ROM word / output symbol
//  ADDR_W  10    ROM address width
//  DEPTH   1024  ROM words present (<= 2**ADDR_W); msg_len is clamped to this
//  BUF_D   2     output skid-buffer entries (>= 2)
// PORTS
//  clk         in   1         system clock, all logic on rising edge
//  reset       in   1         asynchronous, active-high; clears all state
//  start       in   1         begin a message (honoured only in IDLE)
//  loop_en     in   1         1: wrap to addr 0 after last word; sampled at each wrap
//  msg_len     in   ADDR_W+1  words per message, captured on start; 0 = start ignored
//  rom_rd      out  1         ROM read strobe
//  rom_addr    out  ADDR_W    ROM read address, registered
//  rom_data    in   DATA_W    ROM data, valid the cycle after rom_rd
//  data_out    out  DATA_W    output word (buffer head)
//  data_valid  out  1         data_out valid
//  data_ready  in   1         sink accepts; transfer = valid & ready
//  sof         out  1         qualifies data_out as word 0 of a message pass
//  eof         out  1         qualifies data_out as last word of a message pass
//  busy        out  1         high from accepted start until done
//  done        out  1         1-cycle pulse after final eof word is transferred
// BEHAVIOUR
//  - Reset: rom_rd, rom_addr, data_out, data_valid, sof, eof, busy, done = 0.
//    Buffer is emptied, FSM goes to IDLE, and any in-flight read is discarded.
//    Reset has the same effect mid-message.
//  - FSM IDLE -> RUN on start && msg_len!=0; len = min(msg_len, DEPTH) is latched.
//    RUN -> DRAIN when the last read is issued and loop_en==0 at the wrap point.
//    DRAIN -> IDLE when the buffer is empty and the eof word is transferred;
//    done pulses that cycle+1.
//  - start while busy: ignored. Changes to msg_len while busy: no effect.
//  - Reads: rom_rd issued only when (buf_count + inflight - pop) < BUF_D.
//    Buffer never overflows; no word is dropped or duplicated.
//  - Address increments per read. At addr==len-1, the next read goes to 0 if
//    loop_en, otherwise reads stop.
//  - Latency: start sampled at edge T -> rom_rd=1, addr 0 in cycle T+1; rom_data
//    in T+2; data_valid=1 with word 0 and sof=1 in T+3.
//  - Throughput: with data_ready held 1, one word per cycle sustained, no bubbles,
//    including across loop wraps.
//  - Backpressure: while valid && !ready, data_out/sof/eof are held stable. The
//    buffer may fill, and reads stall at BUF_D.
//  - sof/eof travel with their word through the buffer. When len==1, sof and eof
//    are both 1 on the same word.
//  - loop_en dropped mid-pass: the current pass completes to eof, then DRAIN.
// TESTING
//  1 msg_len=5, ROM="HELLO", ready=1, loop_en=0 -> data_valid T+3..T+7.
//    Words 48,45,4C,4C,4F; sof on 48, eof on 4F; done at T+8; busy 0 after.
//  2 Same, ready toggling 1/0 each cycle -> identical word order.
//    Words are held during stalls, rom_rd never outstanding >2, no loss.
//  3 loop_en=1, msg_len=3 ("ABC"), ready=1 -> continuous A,B,C,A,B,C with no gap.
//    sof on each A. Drop loop_en mid-pass -> ends at C with eof, then done.
//  4 msg_len=1 -> single word with sof=eof=1. msg_len=0 -> no rom_rd, busy stays 0.
//    msg_len=2000 with DEPTH=1024 -> 1024 words output.
//  5 reset asserted during pass 1 of test 1 -> all outputs 0 asynchronously.
//    A fresh start afterwards restarts at addr 0 with sof.
//  6 start pulsed while busy -> ignored; the message completes unchanged.

Source files
------------

// File: rtl/text_stream_source.sv
// Streams a message from a 1-cycle-latency synchronous ROM onto a valid/ready
// output with sof/eof markers, optional looping, and credit-limited reads.
module text_stream_source #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int BUF_D  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   msg_len,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              sof,
    output logic              eof,
    output logic              busy,
    output logic              done
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int PTR_W = $clog2(BUF_D);
    localparam int CNT_W = $clog2(BUF_D + 1);
    localparam int LVL_W = CNT_W + 1;

    localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);
    localparam logic [LVL_W-1:0] BUF_L    = LVL_W'(BUF_D);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_D - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_vld_p1;
    logic              r_rd_sof_p1;
    logic              r_rd_eof_p1;
    logic              r_done;

    logic [DATA_W-1:0] r_buf_data [BUF_D];
    logic              r_buf_sof  [BUF_D];
    logic              r_buf_eof  [BUF_D];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_issue;
    logic              w_last;
    logic              w_final;
    logic [LVL_W-1:0]  w_level;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign data_valid = (r_count != '0);
    assign w_pop      = data_valid & data_ready;
    assign data_out   = data_valid ? r_buf_data[r_rd_ptr] : '0;
    assign sof        = data_valid & r_buf_sof[r_rd_ptr];
    assign eof        = data_valid & r_buf_eof[r_rd_ptr];
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign rom_addr   = r_addr;
    assign rom_rd     = w_issue;

    // Occupancy after this cycle's pop, counting the word already on rom_data;
    // issuing only below BUF_D leaves room for the word requested now.
    assign w_level = LVL_W'(r_count) + LVL_W'(r_rd_vld_p1) - LVL_W'(w_pop);
    assign w_issue = (r_state == S_RUN) && (w_level < BUF_L);
    assign w_last  = ({1'b0, r_addr} == (r_len - ONE_LEN));
    // Earlier passes' eof words may still be queued; only the lone last entry ends the message.
    assign w_final = (r_state == S_DRAIN) && w_pop && eof &&
                     (r_count == ONE_CNT) && !r_rd_vld_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_addr      <= '0;
            r_rd_vld_p1 <= 1'b0;
            r_rd_sof_p1 <= 1'b0;
            r_rd_eof_p1 <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_rd_vld_p1 <= w_issue;
            r_rd_sof_p1 <= w_issue && (r_addr == '0);
            r_rd_eof_p1 <= w_issue && w_last;
            case (r_state)
                S_IDLE: begin
                    if (start && (msg_len != '0)) begin
                        r_state <= S_RUN;
                        r_len   <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
                        r_addr  <= '0;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (w_last) begin
                            r_addr <= '0;
                            if (!loop_en) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_final) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer control: push the word returned by last cycle's read, pop on transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_rd_vld_p1) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(r_rd_vld_p1) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (r_rd_vld_p1) begin
            r_buf_data[r_wr_ptr] <= rom_data;
            r_buf_sof[r_wr_ptr]  <= r_rd_sof_p1;
            r_buf_eof[r_wr_ptr]  <= r_rd_eof_p1;
        end
    end

endmodule
